// File: rtl/master_out_port.sv
// Bus master transmitter: handshake then LSB-first serial address/data.
// Optional MASTER_OUT_TXN_CNT_EN adds a 16-bit completed-transaction counter.
module master_out_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  slave_ready,
  output logic                  req_ready,
  output logic                  master_valid,
  output logic                  tx_address,
  output logic                  tx_data,
  output logic                  busy,
  output logic                  tx_done
`ifdef MASTER_OUT_TXN_CNT_EN
  ,
  output logic [15:0]           txn_count
`endif
);

  localparam int CW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(ADDR_WIDTH - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  data_live;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = REQ;
      REQ:     if (slave_ready) state_nxt = SEND;
      SEND:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      addr_sr <= '0;
      data_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_sr <= addr_in;
            data_sr <= data_in;
          end
        end
        REQ: begin
          if (slave_ready) cnt <= '0;
        end
        SEND: begin
          addr_sr <= addr_sr >> 1;
          data_sr <= data_sr >> 1;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data is shorter than address; its line idles low once all bits are out.
  assign data_live = 32'(cnt) < 32'(DATA_WIDTH);

  assign req_ready    = (state == IDLE);
  assign master_valid = (state == REQ);
  assign busy         = (state != IDLE);
  assign tx_done      = (state == DONE);
  assign tx_address   = (state == SEND) & addr_sr[0];
  assign tx_data      = (state == SEND) & data_live & data_sr[0];

`ifdef MASTER_OUT_TXN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              txn_count <= '0;
    else if (state == DONE) txn_count <= txn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_master_out_port.sv
// Bench for master_out_port: vector table, serial scoreboard,
// plus stall, ignored-request, back-to-back and mid-transfer reset sequences.
module tb_master_out_port;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          req;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          slave_ready;
  logic          req_ready;
  logic          master_valid;
  logic          tx_address;
  logic          tx_data;
  logic          busy;
  logic          tx_done;
`ifdef MASTER_OUT_TXN_CNT_EN
  logic [15:0]   txn_count;
`endif

  master_out_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .slave_ready (slave_ready),
    .req_ready   (req_ready),
    .master_valid(master_valid),
    .tx_address  (tx_address),
    .tx_data     (tx_data),
    .busy        (busy),
    .tx_done     (tx_done)
`ifdef MASTER_OUT_TXN_CNT_EN
    ,
    .txn_count   (txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
    int            poke;
  } vec_t;

  exp_t          sb[$];
  exp_t          e;
  logic [AW-1:0] abuf;
  logic [AW-1:0] dbuf;
  int            idx = 0;

  // Serial collector: rebuilds address/data words LSB-first from the lines.
  always @(negedge clk) begin
    if (reset) begin
      idx = 0;
    end else if (busy && !master_valid && !tx_done) begin
      if (idx < AW) begin
        abuf[idx] = tx_address;
        dbuf[idx] = tx_data;
      end
      idx++;
    end else if (tx_done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_bit_count", idx, AW);
        chk("sb_addr", 32'(abuf), 32'(e.addr));
        chk("sb_data", 32'(dbuf), 32'(e.data));
      end
      idx = 0;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t t;
    t.addr = a;
    t.data = d;
    sb.push_back(t);
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, mv_n, done_n, done_c, first_c, ready_c, busy_n;
    bit line_err;
    chk("pre_idle", 32'(req_ready), 32'd1);
    addr_in     = v.addr;
    data_in     = v.data;
    req         = 1'b1;
    slave_ready = (v.stall == 0);
    push_exp(v.addr, v.data);
    @(posedge clk); #1;
    req     = 1'b0;
    addr_in = AW'($urandom);
    data_in = DW'($urandom);
    cyc = 1; mv_n = 0; done_n = 0;
    done_c = -1; first_c = -1; ready_c = -1;
    line_err = 1'b0;
    while (ready_c < 0 && cyc < 80) begin
      @(negedge clk);
      if (master_valid) begin
        mv_n++;
        if (tx_address || tx_data) line_err = 1'b1;
      end
      if (tx_done) begin
        done_n++;
        done_c = cyc;
        if (tx_address || tx_data) line_err = 1'b1;
      end
      if (busy && !master_valid && !tx_done && first_c < 0) first_c = cyc;
      if (req_ready) ready_c = cyc;
      @(posedge clk); #1;
      cyc++;
      slave_ready = (cyc > v.stall);
      req = (v.poke != 0 && cyc == v.poke);
      if (req) addr_in = '1;
    end
    req = 1'b0;
    chk("valid_cycles", mv_n, v.stall + 1);
    chk("first_bit_cycle", first_c, v.stall + 2);
    chk("done_cycle", done_c, v.stall + 14);
    chk("done_pulses", done_n, 1);
    chk("ready_cycle", ready_c, v.stall + 15);
    chk("lines_low_req_done", 32'(line_err), 32'd0);
    busy_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    @(posedge clk); #1;
    chk("no_extra_txn", busy_n, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int dc[$];
    int bad, cyc;
`ifdef MASTER_OUT_TXN_CNT_EN
    logic [15:0] base;
`endif
    vecs[0] = '{12'hA5C, 8'h3B, 0, 0};
    vecs[1] = '{12'h5A3, 8'hC4, 5, 0};
    vecs[2] = '{12'h001, 8'h00, 0, 6};
    vecs[3] = '{12'hFFF, 8'hFF, 0, 0};
    vecs[4] = '{12'h000, 8'h00, 2, 0};
    vecs[5] = '{12'h800, 8'h80, 1, 0};

    reset = 1'b1; req = 1'b0; slave_ready = 1'b0;
    addr_in = '0; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", {master_valid, tx_address, tx_data, busy, tx_done}, 0);
`ifdef MASTER_OUT_TXN_CNT_EN
    chk("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Back-to-back: req held high is accepted at cycles 0, 15, 30.
`ifdef MASTER_OUT_TXN_CNT_EN
    base = txn_count;
`endif
    addr_in = 12'h3C7; data_in = 8'h5E;
    slave_ready = 1'b1;
    repeat (3) push_exp(12'h3C7, 8'h5E);
    req = 1'b1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (tx_done) dc.push_back(cyc);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 31) req = 1'b0;
    end
    chk("b2b_count", dc.size(), 3);
    if (dc.size() == 3) begin
      chk("b2b_done0", dc[0], 14);
      chk("b2b_done1", dc[1], 29);
      chk("b2b_done2", dc[2], 44);
    end
    chk("b2b_idle", 32'(req_ready), 32'd1);
    chk("b2b_sb_empty", sb.size(), 0);
`ifdef MASTER_OUT_TXN_CNT_EN
    chk("b2b_txn_count", 32'(txn_count), 32'(base + 16'd3));
`endif

    // Reset in cycle 6 of a basic write, between clock edges.
    addr_in = 12'hA5C; data_in = 8'h3B;
    push_exp(12'hA5C, 8'h3B);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_lines", {master_valid, tx_address, tx_data, tx_done}, 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_done || busy) bad++;
    end
    @(posedge clk); #1;
    chk("mid_rst_no_done", bad, 0);
    run_txn(vecs[0]);

`ifdef MASTER_OUT_TXN_CNT_EN
    force dut.txn_count = 16'hFFFF;
    #1;
    release dut.txn_count;
    run_txn(vecs[3]);
    chk("txn_count_wrap", 32'(txn_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
